// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler: takes one binary temperature sample over a valid/ready
// handshake, converts it to three BCD digits by sequential shift-add-3, commits
// the digits atomically, and scans them onto a shared active-low 7-segment bus.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-low reset
//   in_data      unsigned sample, DATA_W bits
//   in_valid     sample offered
//   in_ready     block can accept a sample
//   blank        forces all digits dark; conversion and scan keep running
//   busy         conversion in progress
//   update_done  one-cycle pulse when new digits are committed
//   seg          cathodes {a,b,c,d,e,f,g}, active-low
//   an           digit enables, active-low one-hot (an[0]=ones, an[2]=hundreds)
module seg_display_scheduler #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned REFRESH_DIV = 50000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              blank,
   output logic              busy,
   output logic              update_done,
   output logic [6:0]        seg,
   output logic [2:0]        an
);

   localparam int unsigned BCD_W  = 12;
   localparam int unsigned CNT_W  = $clog2(DATA_W + 1);
   localparam int unsigned SCAN_W = $clog2(REFRESH_DIV);
   localparam logic [6:0]  SEG_OFF = 7'b1111111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   bin_q;
   logic [BCD_W-1:0]    bcd_q;
   logic [BCD_W-1:0]    bcd_adj;
   logic [CNT_W-1:0]    bit_cnt;
   logic [3:0]          dig_h;
   logic [3:0]          dig_t;
   logic [3:0]          dig_o;
   logic [SCAN_W-1:0]   scan_cnt;
   logic [1:0]          scan_idx;
   logic [6:0]          seg_c;
   logic [2:0]          an_c;

   // Active-low 7-segment decode, {a,b,c,d,e,f,g}
   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b0000001;
         4'd1:    seg_decode = 7'b1001111;
         4'd2:    seg_decode = 7'b0010010;
         4'd3:    seg_decode = 7'b0000110;
         4'd4:    seg_decode = 7'b1001100;
         4'd5:    seg_decode = 7'b0100100;
         4'd6:    seg_decode = 7'b0100000;
         4'd7:    seg_decode = 7'b0001111;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0000100;
         default: seg_decode = SEG_OFF;
      endcase
   endfunction

   // Add-3 correction on every BCD nibble that would overflow when doubled
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM; status outputs are registered decodes of the current state
   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_IDLE;
         bin_q       <= '0;
         bcd_q       <= '0;
         bit_cnt     <= '0;
         dig_h       <= '0;
         dig_t       <= '0;
         dig_o       <= '0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         update_done <= 1'b0;
      end else begin
         // in_ready drops on the accepting edge so no second handshake can slip in
         in_ready    <= (state == S_IDLE) && !(in_valid && in_ready);
         busy        <= (state == S_CONV);
         update_done <= (state == S_LOAD);
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  bin_q   <= in_data;
                  bcd_q   <= '0;
                  bit_cnt <= '0;
                  state   <= S_CONV;
               end
            end
            S_CONV: begin
               {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
               bit_cnt        <= bit_cnt + CNT_W'(1);
               if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               dig_h <= bcd_q[11:8];
               dig_t <= bcd_q[7:4];
               dig_o <= bcd_q[3:0];
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Digit select with leading-zero blanking; blanked digits keep their an slot
   always_comb begin
      an_c  = 3'b111;
      seg_c = SEG_OFF;
      case (scan_idx)
         2'd0: begin
            an_c  = 3'b110;
            seg_c = seg_decode(dig_o);
         end
         2'd1: begin
            an_c  = 3'b101;
            seg_c = ((dig_h == 4'd0) && (dig_t == 4'd0)) ? SEG_OFF : seg_decode(dig_t);
         end
         2'd2: begin
            an_c  = 3'b011;
            seg_c = (dig_h == 4'd0) ? SEG_OFF : seg_decode(dig_h);
         end
         default: ;
      endcase
   end

   // Free-running scan; seg and an register together so they switch on one edge
   always_ff @(posedge clock) begin
      if (!reset) begin
         scan_cnt <= '0;
         scan_idx <= 2'd0;
         seg      <= SEG_OFF;
         an       <= 3'b111;
      end else begin
         if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
         if (blank) begin
            seg <= SEG_OFF;
            an  <= 3'b111;
         end else begin
            seg <= seg_c;
            an  <= an_c;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Testbench for seg_display_scheduler: directed and randomized stimulus checked
// every cycle against a transaction-level model (accept time, commit time,
// decimal digits by division, scan position from elapsed cycles).
module tb_seg_display_scheduler;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned R      = 4;
   localparam logic [6:0]  OFF    = 7'b1111111;

   logic              clock = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              blank;
   logic              busy;
   logic              update_done;
   logic [6:0]        seg;
   logic [2:0]        an;

   int checks   = 0;
   int failures = 0;

   // Model state: edges since reset release, accept edge, pending and shown values
   int k        = 0;
   int t_acc    = -1000;
   int pend_val = 0;
   int disp_val = 0;
   bit ready_q  = 1'b0;

   logic [6:0] seg_lut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

   always #5 clock = ~clock;

   seg_display_scheduler #(.DATA_W(DATA_W), .REFRESH_DIV(R)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .blank       (blank),
      .busy        (busy),
      .update_done (update_done),
      .seg         (seg),
      .an          (an)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] exp_seg_for(input int v, input int idx);
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      case (idx)
         0:       return seg_lut[o];
         1:       return (h == 0 && t == 0) ? OFF : seg_lut[t];
         default: return (h == 0) ? OFF : seg_lut[h];
      endcase
   endfunction

   // One clock cycle: drive, clock, then compare all outputs against the model
   task automatic step(input logic rst_v, input logic valid_v, input int data_v,
                       input logic blank_v, input string tag);
      int         rel, idx;
      logic [2:0] one_hot;
      logic [2:0] exp_an;
      logic [6:0] exp_seg;
      reset    = rst_v;
      in_valid = valid_v;
      in_data  = DATA_W'(data_v);
      blank    = blank_v;
      @(posedge clock);
      #1;
      if (!rst_v) begin
         k        = 0;
         t_acc    = -1000;
         disp_val = 0;
         ready_q  = 1'b0;
         check({tag, ".rst_seg"},   32'(seg),         32'(OFF));
         check({tag, ".rst_an"},    32'(an),          32'(3'b111));
         check({tag, ".rst_ready"}, 32'(in_ready),    32'(0));
         check({tag, ".rst_busy"},  32'(busy),        32'(0));
         check({tag, ".rst_done"},  32'(update_done), 32'(0));
      end else begin
         k++;
         if (ready_q && valid_v) begin
            t_acc    = k;
            pend_val = int'(in_data);
         end
         rel     = k - t_acc;
         idx     = ((k - 1) / int'(R)) % 3;
         one_hot = 3'(1 << idx);
         exp_an  = blank_v ? 3'b111 : ~one_hot;
         exp_seg = blank_v ? OFF : exp_seg_for(disp_val, idx);
         check({tag, ".seg"},   32'(seg),         32'(exp_seg));
         check({tag, ".an"},    32'(an),          32'(exp_an));
         check({tag, ".ready"}, 32'(in_ready),    32'(rel >= int'(DATA_W) + 2));
         check({tag, ".busy"},  32'(busy),        32'(rel >= 1 && rel <= int'(DATA_W)));
         check({tag, ".done"},  32'(update_done), 32'(rel == int'(DATA_W) + 1));
         if (rel == int'(DATA_W) + 1) disp_val = pend_val;
         ready_q = (rel >= int'(DATA_W) + 2);
      end
   endtask

   task automatic idle(input int n, input logic blank_v, input string tag);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, blank_v, tag);
   endtask

   // Holds in_valid with v until the model says the sample was taken
   task automatic send(input int v, input string tag);
      bit taken;
      taken = 1'b0;
      for (int i = 0; i < 40 && !taken; i++) begin
         taken = ready_q;
         step(1'b1, 1'b1, v, 1'b0, tag);
      end
      if (!taken) check({tag, ".accept_timeout"}, 32'(0), 32'(1));
   endtask

   initial begin
      bit   cur_valid;
      int   cur_data;
      bit   taken;
      logic rst_r, blk_r;
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      blank    = 1'b0;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0, "reset");
      idle(14, 1'b0, "post_reset");

      send(24, "v24");   idle(24, 1'b0, "v24");
      send(255, "v255"); idle(24, 1'b0, "v255");
      send(100, "v100"); idle(24, 1'b0, "v100");
      send(0, "v0");     idle(24, 1'b0, "v0");

      send(23, "hs23");
      send(25, "hs25");
      idle(24, 1'b0, "hs25");

      send(199, "abort");
      idle(3, 1'b0, "abort");
      step(1'b0, 1'b0, 0, 1'b0, "abort_rst");
      step(1'b0, 1'b0, 0, 1'b0, "abort_rst");
      idle(16, 1'b0, "abort_after");

      send(137, "v137"); idle(14, 1'b0, "v137");
      idle(5, 1'b1, "blank_on");
      idle(7, 1'b0, "blank_off");
      idle(3, 1'b1, "blank_on2");
      idle(13, 1'b0, "blank_off2");

      cur_valid = 1'b0;
      cur_data  = 0;
      blk_r     = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!cur_valid && $urandom_range(0, 99) < 30) begin
            cur_valid = 1'b1;
            cur_data  = int'($urandom_range(0, 255));
         end
         if ($urandom_range(0, 99) < 8) blk_r = ~blk_r;
         rst_r = ($urandom_range(0, 199) < 3) ? 1'b0 : 1'b1;
         taken = ready_q && cur_valid && rst_r;
         step(rst_r, cur_valid, cur_data, blk_r, "rand");
         if (taken) cur_valid = 1'b0;
      end
      idle(30, 1'b0, "drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_display_scheduler.md
Name: seg_display_scheduler

Overview:
- Sequencing controller between the temperature datapath and the multiplexed 7-segment display.
- Accepts a binary temperature sample over a valid/ready handshake and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) FSM.
- Commits the three digits atomically to display registers, then time-multiplexes them onto one shared cathode bus with active-low digit enables and leading-zero blanking.

Parameters:
- DATA_W, 8, width of the binary sample; legal range 1..9 so the value always fits 3 decimal digits.
- REFRESH_DIV, 50000, clock cycles each digit is enabled before the scan advances; minimum 2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  DATA_W  unsigned temperature sample.
- in_valid  input  1  sample offered.
- in_ready  output  1  block can accept a sample.
- blank  input  1  forces all digits dark while high; does not stop conversion or scan.
- busy  output  1  conversion in progress.
- update_done  output  1  one-cycle pulse when new digits are committed.
- seg  output  7  cathodes {a,b,c,d,e,f,g}, active-low.
- an  output  3  digit enables, active-low one-hot; an[0]=ones, an[1]=tens, an[2]=hundreds.

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, BCD digits=0, scan counter=0, scan index=0, seg=7'b1111111, an=3'b111, busy=0, update_done=0, in_ready=0. in_ready goes to 1 the cycle after reset deasserts.
- Conversion FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data, clear the BCD shift register, go to CONV.
  - CONV: exactly DATA_W cycles. Each cycle, add 3 to any BCD nibble >=5, then shift left 1 bit, taking the binary MSB into the BCD LSB. busy=1, in_ready=0.
  - LOAD: one cycle. Copy hundreds/tens/ones into the display registers, update_done=1, busy=0, in_ready=0. Next state is IDLE.
- Latency: accept at edge T; display registers hold the new value after edge T+DATA_W+1. in_ready is high again from cycle T+DATA_W+2.
- in_valid while not ready is ignored and not queued; the offering side holds its data.
- Reset asserted mid-CONV or mid-LOAD aborts the conversion and clears the display registers to 0. No partial commit is ever visible.
- Scan:
  - A free-running counter runs 0..REFRESH_DIV-1. On wrap, the scan index advances 0->1->2->0.
  - seg and an are registered from the scan index, so both change on the same edge. There is never a cycle in which a new an is paired with the previous digit's seg.
- Decode (active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank pattern = 1111111.
- Leading-zero blanking:
  - Hundreds digit is blanked when it is 0.
  - Tens digit is blanked when hundreds==0 and tens==0.
  - Ones digit is always shown.
  - A blanked digit drives seg=1111111; its an bit still asserts, keeping scan timing uniform.
- blank==1: seg=1111111 and an=3'b111 from the next edge. The scan counter keeps running.
- Display registers change only in LOAD. The scan never reads the intermediate shift register.

Test Plan:
- Reset behaviour: hold reset low 3 cycles, release -> seg=1111111 and an=111 during reset; in_ready=1 on the first cycle after release; ones digit shows 0000001, tens and hundreds blank.
- Conversion and latency: in_data=8'd24 accepted at edge T -> busy high for cycles T+1..T+8, update_done pulses at T+9, display digits become 0/2/4 after T+9; scan shows ones=1001100 on an=110, tens=0010010 on an=101, hundreds blank on an=011.
- Maximum and boundary values:
  - in_data=8'd255 -> digits 2/5/5.
  - in_data=8'd100 -> hundreds=1001111, tens=0000001 (not blanked), ones=0000001.
  - in_data=0 -> only ones lit.
- Handshake: hold in_valid high continuously with 23 then 25 -> second sample accepted only when in_ready returns (T+DATA_W+2); samples offered while in_ready=0 have no effect; final display shows 25.
- Reset mid-CONV: accept 8'd199, assert reset at T+4 -> no update_done pulse, display reads 0, in_ready=1 one cycle after release.
- Scan and blank (REFRESH_DIV=4):
  - an sequence 110,101,011 repeats every 12 cycles.
  - blank=1 -> an=111 and seg=1111111 on the next edge.
  - Deasserting blank resumes at the current scan index with no phase reset.
